// File: rtl/fp_normalize_pipe_if.sv
// Handshake bundle between the normalizer and its neighbours: an upstream
// beat (in_*) and a downstream beat (out_*), each with valid/ready.
interface fp_normalize_pipe_if #(
    parameter int IN_WIDTH  = 48,
    parameter int OUT_WIDTH = 28,
    parameter int EXP_WIDTH = 10
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_mant;
    logic [EXP_WIDTH-1:0] in_exp;
    logic                 in_sign;
    logic [2:0]           in_mode;

    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_mant;
    logic [EXP_WIDTH-1:0] out_exp;
    logic                 out_sign;
    logic [2:0]           out_mode;
    logic                 out_zero;
    logic                 out_tiny;

    modport master (
        output in_valid, in_mant, in_exp, in_sign, in_mode, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign, out_mode,
               out_zero, out_tiny
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_sign, in_mode, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign, out_mode,
               out_zero, out_tiny
    );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalizer ahead of the rounder: S1 registers the beat and its
// leading-zero count, S2 shifts with an exponent floor of 1 and folds sticky.
module fp_normalize_pipe #(
    parameter int IN_WIDTH  = 48,
    parameter int OUT_WIDTH = 28,
    parameter int EXP_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_normalize_pipe_if.slave     bus
);
    localparam int LZW = $clog2(IN_WIDTH + 1);
    localparam int SW  = EXP_WIDTH + 1;

    // Stage 1 registers
    logic                 s1_valid_reg;
    logic [IN_WIDTH-1:0]  s1_mant_reg;
    logic [EXP_WIDTH-1:0] s1_exp_reg;
    logic                 s1_sign_reg;
    logic [2:0]           s1_mode_reg;
    logic [LZW-1:0]       s1_lzc_reg;

    // Stage 2 (output) registers
    logic                 out_valid_reg;
    logic [OUT_WIDTH-1:0] out_mant_reg;
    logic [EXP_WIDTH-1:0] out_exp_reg;
    logic                 out_sign_reg;
    logic [2:0]           out_mode_reg;
    logic                 out_zero_reg;
    logic                 out_tiny_reg;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv      = !out_valid_reg || bus.out_ready;
    assign s1_adv      = !s1_valid_reg || s2_adv;
    assign bus.in_ready = s1_adv;

    // Leading-zero count; the highest set bit is visited last and wins.
    logic [LZW-1:0] lzc_next;
    always_comb begin
        lzc_next = LZW'(IN_WIDTH);
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (bus.in_mant[i]) begin
                lzc_next = LZW'(IN_WIDTH - 1 - i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_mant_reg  <= '0;
            s1_exp_reg   <= '0;
            s1_sign_reg  <= 1'b0;
            s1_mode_reg  <= 3'b000;
            s1_lzc_reg   <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mant_reg <= bus.in_mant;
                s1_exp_reg  <= bus.in_exp;
                s1_sign_reg <= bus.in_sign;
                s1_mode_reg <= bus.in_mode;
                s1_lzc_reg  <= lzc_next;
            end
        end
    end

    // Shift amount in a widened signed domain so exp-1 never wraps.
    logic signed [SW-1:0]  exp_ext;
    logic signed [SW-1:0]  exp_m1;
    logic signed [SW-1:0]  lzc_ext;
    logic signed [SW-1:0]  sh_raw;
    logic [EXP_WIDTH-1:0]  sh_clamp;
    logic [IN_WIDTH-1:0]   shifted;
    logic                  sticky;
    logic                  s1_zero;
    logic [OUT_WIDTH-1:0]  mant_next;
    logic [EXP_WIDTH-1:0]  exp_next;
    logic                  tiny_next;

    always_comb begin
        exp_ext  = {s1_exp_reg[EXP_WIDTH-1], s1_exp_reg};
        exp_m1   = exp_ext - SW'(1);
        lzc_ext  = {{(SW - LZW){1'b0}}, s1_lzc_reg};
        sh_raw   = (lzc_ext < exp_m1) ? lzc_ext : exp_m1;
        sh_clamp = sh_raw[SW-1] ? '0 : sh_raw[EXP_WIDTH-1:0];
        shifted  = s1_mant_reg << sh_clamp[LZW-1:0];
    end

    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_sticky
            assign sticky = |shifted[IN_WIDTH-OUT_WIDTH-1:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

    always_comb begin
        s1_zero   = ~|s1_mant_reg;
        mant_next = shifted[IN_WIDTH-1 -: OUT_WIDTH];
        mant_next[0] = mant_next[0] | sticky;
        exp_next  = s1_exp_reg - sh_clamp;
        tiny_next = !s1_zero && (sh_clamp < EXP_WIDTH'(s1_lzc_reg));
        if (s1_zero) begin
            mant_next = '0;
            exp_next  = '0;
            tiny_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_mant_reg  <= '0;
            out_exp_reg   <= '0;
            out_sign_reg  <= 1'b0;
            out_mode_reg  <= 3'b000;
            out_zero_reg  <= 1'b0;
            out_tiny_reg  <= 1'b0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_mant_reg <= mant_next;
                out_exp_reg  <= exp_next;
                out_sign_reg <= s1_sign_reg;
                out_mode_reg <= s1_mode_reg;
                out_zero_reg <= s1_zero;
                out_tiny_reg <= tiny_next;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_mant  = out_mant_reg;
    assign bus.out_exp   = out_exp_reg;
    assign bus.out_sign  = out_sign_reg;
    assign bus.out_mode  = out_mode_reg;
    assign bus.out_zero  = out_zero_reg;
    assign bus.out_tiny  = out_tiny_reg;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe: single beats, streaming, backpressure
// and reset while full, each scenario checked against hand-computed results.
module tb_fp_normalize_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fp_normalize_pipe_if #(.IN_WIDTH(48), .OUT_WIDTH(28), .EXP_WIDTH(10)) bus ();

    fp_normalize_pipe #(.IN_WIDTH(48), .OUT_WIDTH(28), .EXP_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drives one beat into an idle pipe and captures its output beat.
    task automatic do_beat(input logic [47:0] m, input logic [9:0] e, input logic s,
                           input logic [2:0] md, output logic rdy, output int lat,
                           output logic [27:0] om, output logic [9:0] oe, output logic os,
                           output logic [2:0] omd, output logic oz, output logic ot);
        logic got;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mant = m; bus.in_exp = e;
        bus.in_sign = s; bus.in_mode = md; bus.out_ready = 1'b1;
        #1 rdy = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mant  = 48'hA5A5_5A5A_F00F;
        bus.in_exp   = 10'h155;
        lat = 1;
        got = bus.out_valid;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = bus.out_valid;
        end
        om = bus.out_mant; oe = bus.out_exp; os = bus.out_sign;
        omd = bus.out_mode; oz = bus.out_zero; ot = bus.out_tiny;
        $display("tx mant=%h exp=%0d -> lat=%0d out_mant=%h out_exp=%0d sign=%b mode=%b zero=%b tiny=%b",
                 m, $signed(e), lat, om, $signed(oe), os, omd, oz, ot);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_mant = '0; bus.in_exp = '0; bus.in_sign = 1'b0; bus.in_mode = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_mode,
             bus.out_zero, bus.out_tiny} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b mant=%h exp=%h sign=%b mode=%b zero=%b tiny=%b want all 0",
                     bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_mode,
                     bus.out_zero, bus.out_tiny);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
        $display("tx reset released in_ready=%b", bus.in_ready);
    endtask

    // Single beats: list of (mant, exp, sign, mode) with expected results.
    task automatic run_vectors(input string tag, input int n, input logic [47:0] vm[8],
                               input logic [9:0] ve[8], input logic vs[8], input logic [2:0] vmd[8],
                               input logic [27:0] xm[8], input logic [9:0] xe[8],
                               input logic xz[8], input logic xt[8]);
        logic rdy, os, oz, ot;
        int lat;
        logic [27:0] om;
        logic [9:0] oe;
        logic [2:0] omd;
        for (int k = 0; k < n; k++) begin
            do_beat(vm[k], ve[k], vs[k], vmd[k], rdy, lat, om, oe, os, omd, oz, ot);
            checks++;
            if (rdy !== 1'b1 || lat != 2) begin
                failures++;
                $display("FAIL %s_%0d_latency got in_ready=%b lat=%0d want 1/2", tag, k, rdy, lat);
            end
            checks++;
            if ({om, oe, oz, ot} !== {xm[k], xe[k], xz[k], xt[k]}) begin
                failures++;
                $display("FAIL %s_%0d_value got mant=%h exp=%h zero=%b tiny=%b want mant=%h exp=%h zero=%b tiny=%b",
                         tag, k, om, oe, oz, ot, xm[k], xe[k], xz[k], xt[k]);
            end
            checks++;
            if ({os, omd} !== {vs[k], vmd[k]}) begin
                failures++;
                $display("FAIL %s_%0d_passthru got sign=%b mode=%b want sign=%b mode=%b",
                         tag, k, os, omd, vs[k], vmd[k]);
            end
        end
    endtask

    task automatic test_normalize;
        logic [47:0] vm[8]; logic [9:0] ve[8]; logic vs[8]; logic [2:0] vmd[8];
        logic [27:0] xm[8]; logic [9:0] xe[8]; logic xz[8]; logic xt[8];
        for (int k = 0; k < 8; k++) begin
            vm[k] = '0; ve[k] = '0; vs[k] = 1'b0; vmd[k] = '0;
            xm[k] = '0; xe[k] = '0; xz[k] = 1'b0; xt[k] = 1'b0;
        end
        vm[0] = 48'h8000_0000_0000; ve[0] = 10'd100; vs[0] = 1'b0; vmd[0] = 3'b000;
        xm[0] = 28'h800_0000;      xe[0] = 10'd100;
        vm[1] = 48'h0000_0000_0001; ve[1] = 10'd200; vs[1] = 1'b1; vmd[1] = 3'b001;
        xm[1] = 28'h800_0000;      xe[1] = 10'd153;
        vm[2] = 48'h8000_0000_0001; ve[2] = 10'd10;  vs[2] = 1'b0; vmd[2] = 3'b100;
        xm[2] = 28'h800_0001;      xe[2] = 10'd10;
        // lzc 9, exp 511: shifted bit 47, bit 8 lands below the window -> sticky
        vm[3] = 48'h0040_0000_0100; ve[3] = 10'd511; vs[3] = 1'b1; vmd[3] = 3'b010;
        xm[3] = 28'h800_0001;      xe[3] = 10'd502;
        run_vectors("normalize", 4, vm, ve, vs, vmd, xm, xe, xz, xt);
    endtask

    task automatic test_tiny_and_zero;
        logic [47:0] vm[8]; logic [9:0] ve[8]; logic vs[8]; logic [2:0] vmd[8];
        logic [27:0] xm[8]; logic [9:0] xe[8]; logic xz[8]; logic xt[8];
        for (int k = 0; k < 8; k++) begin
            vm[k] = '0; ve[k] = '0; vs[k] = 1'b0; vmd[k] = '0;
            xm[k] = '0; xe[k] = '0; xz[k] = 1'b0; xt[k] = 1'b0;
        end
        vm[0] = 48'h0001_0000_0000; ve[0] = 10'd5;   vmd[0] = 3'b001;
        xm[0] = 28'h001_0000;      xe[0] = 10'd1;   xt[0] = 1'b1;
        vm[1] = 48'h0100_0000_0000; ve[1] = 10'd1;   vs[1] = 1'b1;
        xm[1] = 28'h010_0000;      xe[1] = 10'd1;   xt[1] = 1'b1;
        // exp -512: exp-1 must not wrap to +511, so no shift happens
        vm[2] = 48'h0000_0000_0001; ve[2] = 10'h200; vmd[2] = 3'b010;
        xm[2] = 28'h000_0001;      xe[2] = 10'h200; xt[2] = 1'b1;
        vm[3] = 48'h8000_0000_0000; ve[3] = 10'h3FD;
        xm[3] = 28'h800_0000;      xe[3] = 10'h3FD; xt[3] = 1'b0;
        vm[4] = 48'h0;              ve[4] = 10'd77;  vs[4] = 1'b1; vmd[4] = 3'b011;
        xm[4] = 28'h0;             xe[4] = 10'd0;   xz[4] = 1'b1;
        run_vectors("tiny_zero", 5, vm, ve, vs, vmd, xm, xe, xz, xt);
    endtask

    task automatic test_back_to_back;
        logic [47:0] vm[3]; logic [9:0] ve[3]; logic [27:0] xm[3]; logic [9:0] xe[3]; logic xt[3];
        vm[0] = 48'h8000_0000_0001; ve[0] = 10'd10;  xm[0] = 28'h800_0001; xe[0] = 10'd10;  xt[0] = 1'b0;
        vm[1] = 48'h0001_0000_0000; ve[1] = 10'd5;   xm[1] = 28'h001_0000; xe[1] = 10'd1;   xt[1] = 1'b1;
        vm[2] = 48'h0000_0000_0001; ve[2] = 10'd200; xm[2] = 28'h800_0000; xe[2] = 10'd153; xt[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_early_valid got out_valid=%b want 0", bus.out_valid);
                end
            end
            if (i >= 2) begin
                checks++;
                if ({bus.out_valid, bus.out_mant, bus.out_exp, bus.out_tiny} !==
                    {1'b1, xm[i-2], xe[i-2], xt[i-2]}) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got valid=%b mant=%h exp=%h tiny=%b want 1 %h %h %b",
                             i - 2, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_tiny,
                             xm[i-2], xe[i-2], xt[i-2]);
                end
                $display("tx b2b out beat%0d mant=%h exp=%0d", i - 2, bus.out_mant, $signed(bus.out_exp));
            end
            bus.out_ready = 1'b1;
            bus.in_valid  = (i < 3);
            if (i < 3) begin
                bus.in_mant = vm[i]; bus.in_exp = ve[i]; bus.in_sign = 1'b0; bus.in_mode = 3'b000;
            end
            #1;
            if (i < 3) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready_%0d got %b want 1", i, bus.in_ready);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure_reset;
        logic [47:0] bm[4]; logic [9:0] be[4]; logic [9:0] xe[4];
        logic [47:0] top;
        logic last_rdy;
        int acc;
        top = 48'h8000_0000_0000;
        for (int k = 0; k < 4; k++) begin
            bm[k] = top >> k;
            be[k] = 10'(20 * (k + 1));
        end
        xe[0] = 10'd20; xe[1] = 10'd39; xe[2] = 10'd58; xe[3] = 10'd77;
        @(negedge clk);   // drain any beat still in the pipe
        acc = 0;
        last_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0; bus.in_valid = 1'b1;
            bus.in_mant = bm[acc]; bus.in_exp = be[acc];
            bus.in_sign = acc[0]; bus.in_mode = 3'(acc);
            #1 last_rdy = bus.in_ready;
            if (last_rdy) acc++;
        end
        $display("tx backpressure accepted=%0d in_ready=%b", acc, last_rdy);
        checks++;
        if (acc != 2 || last_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept_count got accepted=%0d in_ready=%b want 2/0", acc, last_rdy);
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_mode} !==
                {1'b1, 1'b0, 28'h800_0000, xe[0], 1'b0, 3'b000}) begin
                failures++;
                $display("FAIL bp_hold_%0d got valid=%b in_ready=%b mant=%h exp=%h want 1 0 8000000 %h",
                         h, bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp, xe[0]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_mode} !==
                {1'b1, 28'h800_0000, xe[k], k[0], 3'(k)}) begin
                failures++;
                $display("FAIL bp_release_beat%0d got valid=%b mant=%h exp=%h sign=%b mode=%b want exp=%h",
                         k, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_sign, bus.out_mode, xe[k]);
            end
            $display("tx release out beat%0d exp=%0d", k, $signed(bus.out_exp));
            bus.out_ready = 1'b1;
            if (acc < 4) begin
                bus.in_valid = 1'b1; bus.in_mant = bm[acc]; bus.in_exp = be[acc];
                bus.in_sign = acc[0]; bus.in_mode = 3'(acc);
                #1 if (bus.in_ready) acc++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        // Refill with out_ready low, then reset while full.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = (c < 2);
            bus.in_mant = bm[c]; bus.in_exp = be[c];
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_full_precond got out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_full got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_discard_%0d got out_valid=%b want 0", c, bus.out_valid);
            end
        end
        $display("tx reset while full discarded in-flight beats");
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_tiny_and_zero();
        test_back_to_back();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got no completion want finish");
        $fatal(1, "timeout");
    end
endmodule
